bldc_commutation_ctrl: RTL
==========================

# bldc_commutation_ctrl

Six-step commutation controller for the BLDC motor drive. It reads the three hall sensors (H1–H3) and a 4-bit duty command (D3..D0), and drives the six bridge gate enables. It sequences the commutation table for either direction, soft-starts the applied duty, enforces dead time at every step change, measures rotor period, and latches faults on an invalid hall code or a stall. It sits between the hall/duty inputs and the gate-drive outputs of the top-level motor schematic.

## Interface
- DEB_CYCLES, 4: cycles a synchronized hall code must hold stable before acceptance (1..15)
- DEAD_CYCLES, 2: all-gates-off cycles inserted at each step change (0..7)
- RAMP_DIV, 256: cycles per +1 step of applied duty during ramp-up (≥1)
- STALL_CYCLES, 50000: cycles without an accepted hall change before stall fault (< 65535)

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST_N  in  1  synchronous reset, active-low
- H1, H2, H3  in  1  raw hall sensor inputs (asynchronous)
- EN  in  1  run enable
- DIR  in  1  0 = forward, 1 = reverse
- D3, D2, D1, D0  in  1  duty command, D3 = MSB, 0..15
- AH, AL, BH, BL, CH, CL  out  1  gate enables, registered
- FAULT  out  1  sticky fault flag
- FCODE  out  2  01 = invalid hall, 10 = stall, 00 = none
- PERIOD  out  16  cycles between the last two accepted hall changes, saturating at 16'hFFFF

## Operation
- Hall path: 2-FF synchronizer on {H3,H2,H1}, then a debounce counter. The accepted code HC updates after DEB_CYCLES consecutive identical synchronized samples.
- FSM states: IDLE, RUN, FLT.
  - IDLE: all gates off; applied duty DA = 0. Go to RUN when EN = 1 and HC is valid.
  - RUN: outputs follow the commutation table. EN = 0 returns to IDLE the next cycle.
  - FLT: all gates off, FAULT = 1. Go to IDLE only when EN = 0.
- Invalid hall: HC = 000 or 111 while in RUN → FLT, FCODE = 01. In IDLE an invalid HC only blocks entry to RUN.
- Stall: a 16-bit counter clears on each accepted HC change and is held at 0 outside RUN. Reaching STALL_CYCLES → FLT, FCODE = 10.
- Forward table ({H3,H2,H1} → high/low pair):
  - 101 → AH/BL
  - 100 → AH/CL
  - 110 → BH/CL
  - 010 → BH/AL
  - 011 → CH/AL
  - 001 → CH/BL
- Reverse table: same entries with high and low swapped (101 → BH/AL, and so on).
- PWM: free-running 4-bit counter P with period 16. The selected high-side gate is on when P < DA. The selected low-side gate is on for the whole step. DA = 0 → high side never on; DA = 15 → on 15 of 16 cycles.
- Soft start: in RUN, if D < DA then DA = D immediately. If D > DA then DA increments by 1 every RAMP_DIV cycles until it equals D.
- Dead time: on any change of the selected pair (hall step or DIR change), all six gates are off for DEAD_CYCLES, then the new pair is driven.
- A high and low gate of the same phase are never both 1. This is an invariant to be asserted.
- PERIOD: a cycle counter cleared on each accepted HC change in RUN. Its value is latched into PERIOD on that change.

## Timing
- Reset (RST_N = 0 at an edge): state IDLE; all gates 0; FAULT 0; FCODE 00; PERIOD 0; DA 0; P 0; all counters 0. Reset overrides everything, including a reset asserted mid-step or in FLT.
- Hall latency: a raw hall change settles into the synchronizer in 2 cycles. HC updates DEB_CYCLES cycles later. Gates go off on the next edge, then the new pair is driven after DEAD_CYCLES.
- Glitches shorter than DEB_CYCLES are ignored.
- EN 1→0 in RUN: gates 0 on the next edge; DA cleared.
- A fault and a hall change on the same cycle: the fault wins and the FCODE of the first detected fault is kept. If invalid-hall and stall are detected on the same cycle, invalid-hall (01) wins.
- PERIOD counter saturates at 16'hFFFF; it does not wrap.

## Test plan
- Reset: hold RST_N = 0 for 3 cycles with EN = 1 and H = 101 → all gates 0, FAULT = 0, PERIOD = 0; after release, RUN entered within DEB_CYCLES + 3 cycles.
- Forward rotation: D = 6, EN = 1, DIR = 0, hall sequence 101,100,110,010,011,001 with 500 cycles per step →
  - pairs follow the forward table;
  - DA reaches 6 after 6×RAMP_DIV cycles;
  - AH duty is 6/16 once ramped;
  - PERIOD = 500;
  - DEAD_CYCLES all-off gap at every step.
- Reverse plus a DIR toggle mid-step: H = 101, DIR 0→1 → AH/BL off for DEAD_CYCLES, then BH/AL driven.
- Invalid hall: drive H = 111 in RUN → FLT, FCODE = 01, gates 0; FAULT stays 1 with H restored; EN = 0 → IDLE, FAULT = 0.
- Stall: hold H = 100 in RUN → FAULT asserts exactly STALL_CYCLES cycles after the last accepted change, FCODE = 10.
- Debounce and duty step-down: a hall glitch of DEB_CYCLES−1 cycles → no step change; D 15→3 while DA = 15 → DA = 3 on the next cycle.

Source files
------------

// File: rtl/bldc_commutation_ctrl.sv
// bldc_commutation_ctrl
//   Six-step BLDC commutation controller. It synchronizes and debounces the
//   hall sensors and selects the high/low bridge pair from the commutation
//   table for either direction. It PWMs the high side at the applied duty,
//   which soft-starts toward the command. All gates are blanked for a dead
//   time at every pair change. The block also measures the rotor step period
//   and latches invalid-hall and stall faults.
//
// Ports
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   h1_i, h2_i, h3_i        raw hall inputs (asynchronous)
//   en_i                    run enable
//   dir_i                   0 = forward, 1 = reverse
//   d3_i..d0_i              duty command, d3_i = MSB
//   ah_o..cl_o              registered gate enables
//   fault_o, fcode_o        sticky fault flag, 01 invalid hall / 10 stall
//   period_o                cycles between the last two accepted hall changes
module bldc_commutation_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int DEAD_CYCLES  = 2,
  parameter int RAMP_DIV     = 256,
  parameter int STALL_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        h1_i,
  input  logic        h2_i,
  input  logic        h3_i,
  input  logic        en_i,
  input  logic        dir_i,
  input  logic        d3_i,
  input  logic        d2_i,
  input  logic        d1_i,
  input  logic        d0_i,
  output logic        ah_o,
  output logic        al_o,
  output logic        bh_o,
  output logic        bl_o,
  output logic        ch_o,
  output logic        cl_o,
  output logic        fault_o,
  output logic [1:0]  fcode_o,
  output logic [15:0] period_o
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLT = 2'd2} state_e;

  // ---------------- hall synchronizer + debounce ----------------
  logic [2:0] sync1_q, sync2_q, cand_q, hc_q;
  logic [3:0] deb_q;
  logic       same, accept, hc_chg;

  // deb_q counts consecutive identical samples of cand_q. A code is accepted
  // on the sample that completes the DEB_CYCLES-long run.
  assign same   = (sync2_q == cand_q);
  assign accept = same ? (deb_q == 4'(DEB_CYCLES - 1)) : (DEB_CYCLES == 1);
  assign hc_chg = accept && (sync2_q != hc_q);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      deb_q   <= '0;
      hc_q    <= '0;
    end else begin
      sync1_q <= {h3_i, h2_i, h1_i};
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      if (!same)                         deb_q <= 4'd1;
      else if (deb_q != 4'(DEB_CYCLES))  deb_q <= deb_q + 4'd1;
      if (accept) hc_q <= sync2_q;
    end
  end

  // ---------------- commutation table ----------------
  // Returns {hi[2:0], lo[2:0]} as one-hot phase masks, bit2 = A, bit0 = C.
  // Reverse swaps the high and low phase of every entry.
  function automatic logic [5:0] pair_of(input logic [2:0] h, input logic dir);
    logic [2:0] hi, lo;
    hi = 3'b000;
    lo = 3'b000;
    case (h)
      3'b101: begin hi = 3'b100; lo = 3'b010; end
      3'b100: begin hi = 3'b100; lo = 3'b001; end
      3'b110: begin hi = 3'b010; lo = 3'b001; end
      3'b010: begin hi = 3'b010; lo = 3'b100; end
      3'b011: begin hi = 3'b001; lo = 3'b100; end
      3'b001: begin hi = 3'b001; lo = 3'b010; end
      default: ;
    endcase
    return dir ? {lo, hi} : {hi, lo};
  endfunction

  // Gate vector order {AH, AL, BH, BL, CH, CL}.
  function automatic logic [5:0] drive(input logic [5:0] pair, input logic pwm_on);
    logic [5:0] g;
    for (int i = 0; i < 3; i++) begin
      g[2*i+1] = pair[3+i] & pwm_on;
      g[2*i]   = pair[i];
    end
    return g;
  endfunction

  // ---------------- control FSM ----------------
  state_e        state_q, state_d;
  logic [5:0]    gates_q, gates_d;
  logic [5:0]    pair_q, pair_d;
  logic [2:0]    dead_q, dead_d;
  logic [3:0]    da_q, da_d, p_q, p_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [15:0]   stall_q, stall_d, per_q, per_d, period_q, period_d;
  logic          fault_q, fault_d;
  logic [1:0]    fcode_q, fcode_d;
  logic [3:0]    duty;
  logic [5:0]    sel;
  logic          hc_valid;

  assign duty     = {d3_i, d2_i, d1_i, d0_i};
  assign sel      = pair_of(hc_q, dir_i);
  assign hc_valid = (hc_q != 3'b000) && (hc_q != 3'b111);

  always_comb begin
    state_d  = state_q;
    gates_d  = '0;
    pair_d   = '0;
    dead_d   = '0;
    da_d     = '0;
    ramp_d   = '0;
    stall_d  = '0;
    per_d    = '0;
    period_d = period_q;
    fault_d  = fault_q;
    fcode_d  = fcode_q;
    p_d      = p_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (en_i && hc_valid) state_d = S_RUN;
      end
      S_RUN: begin
        // Faults take priority over a simultaneous hall step; invalid hall
        // outranks stall.
        if (!hc_valid) begin
          state_d = S_FLT;
          fault_d = 1'b1;
          fcode_d = 2'b01;
        end else if (stall_q == 16'(STALL_CYCLES - 1)) begin
          state_d = S_FLT;
          fault_d = 1'b1;
          fcode_d = 2'b10;
        end else if (!en_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          stall_d = hc_chg ? 16'd0 : stall_q + 16'd1;
          per_d   = (hc_chg || per_q == 16'hFFFF) ? (hc_chg ? 16'd0 : 16'hFFFF)
                                                   : per_q + 16'd1;
          // The step that ends now includes the current cycle.
          if (hc_chg) period_d = (per_q == 16'hFFFF) ? 16'hFFFF : per_q + 16'd1;

          // Soft start: drop immediately, climb one step per RAMP_DIV cycles.
          da_d = da_q;
          if (duty < da_q) begin
            da_d = duty;
          end else if (duty > da_q) begin
            if (ramp_q == RW'(RAMP_DIV - 1)) da_d = da_q + 4'd1;
            else                             ramp_d = ramp_q + 1'b1;
          end

          // Any pair change (hall step or DIR flip) blanks all gates first.
          pair_d = pair_q;
          dead_d = dead_q;
          if (sel != pair_q) begin
            pair_d = sel;
            dead_d = 3'(DEAD_CYCLES);
          end else if (dead_q != 3'd0) begin
            dead_d = dead_q - 3'd1;
          end
          if (dead_d == 3'd0) gates_d = drive(pair_d, p_q < da_q);
        end
      end
      S_FLT: begin
        if (!en_i) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          fcode_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      gates_q  <= '0;
      pair_q   <= '0;
      dead_q   <= '0;
      da_q     <= '0;
      p_q      <= '0;
      ramp_q   <= '0;
      stall_q  <= '0;
      per_q    <= '0;
      period_q <= '0;
      fault_q  <= 1'b0;
      fcode_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      gates_q  <= gates_d;
      pair_q   <= pair_d;
      dead_q   <= dead_d;
      da_q     <= da_d;
      p_q      <= p_d;
      ramp_q   <= ramp_d;
      stall_q  <= stall_d;
      per_q    <= per_d;
      period_q <= period_d;
      fault_q  <= fault_d;
      fcode_q  <= fcode_d;
    end
  end

  assign {ah_o, al_o, bh_o, bl_o, ch_o, cl_o} = gates_q;
  assign fault_o  = fault_q;
  assign fcode_o  = fcode_q;
  assign period_o = period_q;

  a_no_shoot_through: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !((gates_q[5] & gates_q[4]) | (gates_q[3] & gates_q[2]) | (gates_q[1] & gates_q[0])));

endmodule
